// File: rtl/car_uart_pkg.sv
// car_uart_pkg
// Shared definitions for the 24-bit UART frame transmitter:
//   - uart_state_e : transmitter FSM states
//   - SYNC_NIBBLE  : marker nibble carried in the top half of byte0
//   - FRAME_BYTES  : number of UART bytes per frame
//   - PAYLOAD_W    : width of the request payload
//   - clks_per_bit : clock cycles per serial bit for a clock/baud pair
//   - frame_byte   : selects byte 0..2 of a frame from the payload
package car_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;
  localparam int         FRAME_BYTES = 3;
  localparam int         PAYLOAD_W   = 20;

  // Integer division truncates, so this is floor(clk_freq / baud).
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Byte0 carries the sync nibble ahead of the top four payload bits.
  function automatic logic [7:0] frame_byte(input logic [PAYLOAD_W-1:0] data,
                                            input logic [1:0]           idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {SYNC_NIBBLE, data[19:16]};
      2'd1:    b = data[15:8];
      2'd2:    b = data[7:0];
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tx_24bits_if.sv
// tx_24bits_if
// Request/line bundle of the 24-bit UART transmitter.
//   tx_data [19:0] : payload ([19:10] control_x, [9:0] control_y)
//   tx_vld         : request to send tx_data as one frame
//   tx_rdy         : transmitter can accept a request
//   tx             : serial line, idle high
//   tx_done        : one-cycle pulse when the final stop bit completes
// master = requester side, slave = transmitter side.
interface tx_24bits_if;

  logic [car_uart_pkg::PAYLOAD_W-1:0] tx_data;
  logic                               tx_vld;
  logic                               tx_rdy;
  logic                               tx;
  logic                               tx_done;

  modport master (
    output tx_data,
    output tx_vld,
    input  tx_rdy,
    input  tx,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_vld,
    output tx_rdy,
    output tx,
    output tx_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Bit-time divider: while enabled, bit_tick is high for one cycle every
// CLKS_PER_BIT cycles. clear restarts the count so the following bit is
// full length.
//   CLK      : clock, rising edge
//   RST      : synchronous reset, active-low
//   clear    : restart count from zero (frame start)
//   enable   : count while a frame is in progress
//   bit_tick : last cycle of the current bit time
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int              CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Baud counter 0..CLKS_PER_BIT-1, wrapping at the end of each bit.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      if (cnt_r == CNT_MAX) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bit_tick = enable && !clear && (cnt_r == CNT_MAX);

endmodule

// File: rtl/tx_24bits.sv
// tx_24bits
// Sends a 20-bit payload as three back-to-back 8N1 UART bytes:
//   byte0 = {4'hA, tx_data[19:16]}, byte1 = tx_data[15:8], byte2 = tx_data[7:0].
// A request is taken when tx_vld and tx_rdy are both high; the start bit of
// byte0 appears on the following cycle. All outputs are registered.
//   CLK, RST : clock and synchronous active-low reset
//   bus      : tx_24bits_if.slave (tx_data, tx_vld, tx_rdy, tx, tx_done)
//   CLK_FREQ : clock frequency in Hz;  BAUD : bit rate in bit/s
module tx_24bits
  import car_uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic         CLK,
  input  logic         RST,
  tx_24bits_if.slave   bus
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  uart_state_e          state_r, state_nxt_s;
  logic [PAYLOAD_W-1:0] data_r, data_nxt_s;
  logic [2:0]           bit_idx_r, bit_idx_nxt_s;
  logic [1:0]           byte_idx_r, byte_idx_nxt_s;
  logic                 tx_r, tx_nxt_s;
  logic                 tx_rdy_r, tx_rdy_nxt_s;
  logic                 tx_done_r, tx_done_nxt_s;
  logic                 accept_s;
  logic                 bit_tick_s;
  logic                 baud_en_s;
  logic [7:0]           cur_byte_s;

  assign accept_s   = (state_r == IDLE) && tx_rdy_r && bus.tx_vld;
  assign baud_en_s  = (state_r != IDLE);
  assign cur_byte_s = frame_byte(data_r, byte_idx_r);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (accept_s),
    .enable   (baud_en_s),
    .bit_tick (bit_tick_s)
  );

  // State, counters, payload and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r    <= IDLE;
      data_r     <= {PAYLOAD_W{1'b0}};
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 2'd0;
      tx_r       <= 1'b1;
      tx_rdy_r   <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      data_r     <= data_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      byte_idx_r <= byte_idx_nxt_s;
      tx_r       <= tx_nxt_s;
      tx_rdy_r   <= tx_rdy_nxt_s;
      tx_done_r  <= tx_done_nxt_s;
    end
  end

  // Next-state logic; tx is computed one cycle ahead so the line is a flop.
  always_comb begin
    state_nxt_s    = state_r;
    data_nxt_s     = data_r;
    bit_idx_nxt_s  = bit_idx_r;
    byte_idx_nxt_s = byte_idx_r;
    tx_nxt_s       = tx_r;
    tx_rdy_nxt_s   = tx_rdy_r;
    tx_done_nxt_s  = 1'b0;

    case (state_r)
      IDLE: begin
        tx_nxt_s     = 1'b1;
        tx_rdy_nxt_s = 1'b1;
        if (accept_s) begin
          state_nxt_s    = START;
          data_nxt_s     = bus.tx_data;
          bit_idx_nxt_s  = 3'd0;
          byte_idx_nxt_s = 2'd0;
          tx_nxt_s       = 1'b0;
          tx_rdy_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      START: begin
        if (bit_tick_s) begin
          state_nxt_s   = DATA;
          bit_idx_nxt_s = 3'd0;
          tx_nxt_s      = cur_byte_s[0];
        end else begin
          state_nxt_s = START;
        end
      end

      DATA: begin
        if (bit_tick_s) begin
          if (bit_idx_r == 3'd7) begin
            state_nxt_s   = STOP;
            bit_idx_nxt_s = 3'd0;
            tx_nxt_s      = 1'b1;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
            tx_nxt_s      = cur_byte_s[bit_idx_r + 3'd1];
          end
        end else begin
          state_nxt_s = DATA;
        end
      end

      STOP: begin
        if (bit_tick_s) begin
          if (byte_idx_r == 2'(FRAME_BYTES - 1)) begin
            // Frame complete: ready again in the same cycle as the done pulse.
            state_nxt_s    = IDLE;
            byte_idx_nxt_s = 2'd0;
            tx_nxt_s       = 1'b1;
            tx_rdy_nxt_s   = 1'b1;
            tx_done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s    = START;
            byte_idx_nxt_s = byte_idx_r + 2'd1;
            tx_nxt_s       = 1'b0;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end

      default: begin
        state_nxt_s    = IDLE;
        bit_idx_nxt_s  = 3'd0;
        byte_idx_nxt_s = 2'd0;
        tx_nxt_s       = 1'b1;
        tx_rdy_nxt_s   = 1'b0;
      end
    endcase
  end

  assign bus.tx      = tx_r;
  assign bus.tx_rdy  = tx_rdy_r;
  assign bus.tx_done = tx_done_r;

endmodule

// File: tb/tb_tx_24bits.sv
// tb_tx_24bits
// Self-checking bench for tx_24bits at CLK_FREQ=160, BAUD=10 (16 cycles/bit).
// A reference model builds the 30-bit line image of a frame from the payload;
// each frame's line is captured cycle by cycle and compared both mid-bit
// (byte decode) and on every cycle (exact bit widths).
module tb_tx_24bits;

  localparam int CPB       = 16;
  localparam int NBITS     = 30;
  localparam int FRAME_CYC = NBITS * CPB;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  tx_24bits_if bus_if ();

  tx_24bits #(
    .CLK_FREQ (160),
    .BAUD     (10)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Line image in transmission order: bit n = byte n/10, position n%10
  // (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic [NBITS-1:0] model_frame(input logic [19:0] p);
    logic [NBITS-1:0] f;
    int pv;
    int bv;
    pv = int'(p);
    f  = '0;
    for (int j = 0; j < 3; j++) begin
      if (j == 0)      bv = 10 * 16 + pv / 65536;
      else if (j == 1) bv = (pv / 256) % 256;
      else             bv = pv % 256;
      for (int k = 0; k < 10; k++) begin
        if (k == 0)      f[j*10+k] = 1'b0;
        else if (k == 9) f[j*10+k] = 1'b1;
        else             f[j*10+k] = ((bv >> (k - 1)) & 1) != 0;
      end
    end
    return f;
  endfunction

  // mode 0: plain frame (payload input scrambled after acceptance)
  // mode 1: extra request at frame cycle 100 must be ignored
  // mode 2: tx_vld stays high; p2 is presented for the next frame
  // mode 3: reset asserted at frame cycle 200
  task automatic run_frame(input logic [19:0] p, input int mode, input logic [19:0] p2);
    logic [NBITS-1:0]     expv;
    logic [FRAME_CYC-1:0] samp;
    logic [9:0]           got_b;
    int width_err, rdy_err, done_err, idle_err;
    bit aborted;
    expv      = model_frame(p);
    samp      = '0;
    width_err = 0;
    rdy_err   = 0;
    done_err  = 0;
    aborted   = 1'b0;

    check_val("rdy_before_req", 32'(bus_if.tx_rdy), 32'd1);
    bus_if.tx_data = p;
    bus_if.tx_vld  = 1'b1;
    step();
    if (mode != 2) begin
      bus_if.tx_vld = 1'b0;
      if (mode == 0) bus_if.tx_data = 20'($urandom);
    end

    for (int c = 0; c < FRAME_CYC; c++) begin
      samp[c] = bus_if.tx;
      if (bus_if.tx !== expv[c / CPB]) width_err++;
      if (bus_if.tx_rdy !== 1'b0) rdy_err++;
      if (bus_if.tx_done !== 1'b0) done_err++;
      if (mode == 1 && c == 100) begin
        bus_if.tx_vld  = 1'b1;
        bus_if.tx_data = 20'h00001;
      end
      if (mode == 1 && c == 101) bus_if.tx_vld = 1'b0;
      if (mode == 3 && c == 200) begin
        RST     = 1'b0;
        aborted = 1'b1;
        break;
      end
      step();
    end

    check_val("line_bit_width", 32'(width_err), 32'd0);
    check_val("rdy_low_in_frame", 32'(rdy_err), 32'd0);
    check_val("done_low_in_frame", 32'(done_err), 32'd0);

    if (aborted) begin
      step();
      check_val("rst_tx_high", 32'(bus_if.tx), 32'd1);
      check_val("rst_rdy_low", 32'(bus_if.tx_rdy), 32'd0);
      check_val("rst_done_low", 32'(bus_if.tx_done), 32'd0);
      step();
      step();
      RST = 1'b1;
      step();
      check_val("rdy_after_release", 32'(bus_if.tx_rdy), 32'd1);
      idle_err = 0;
      for (int c = 0; c < 600; c++) begin
        if (bus_if.tx !== 1'b1 || bus_if.tx_done !== 1'b0 || bus_if.tx_rdy !== 1'b1) idle_err++;
        step();
      end
      check_val("no_resume_after_rst", 32'(idle_err), 32'd0);
      return;
    end

    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 10; k++) got_b[k] = samp[j*10*CPB + k*CPB + CPB/2];
      check_val("byte_decode", 32'(got_b), 32'(expv[j*10 +: 10]));
    end

    check_val("done_at_480", 32'(bus_if.tx_done), 32'd1);
    check_val("rdy_at_done", 32'(bus_if.tx_rdy), 32'd1);
    check_val("tx_idle_at_done", 32'(bus_if.tx), 32'd1);

    if (mode == 2) begin
      bus_if.tx_data = p2;
      return;
    end

    step();
    check_val("done_one_cycle", 32'(bus_if.tx_done), 32'd0);
    if (mode == 1) begin
      idle_err = 0;
      for (int c = 0; c < 100; c++) begin
        if (bus_if.tx !== 1'b1 || bus_if.tx_rdy !== 1'b1 || bus_if.tx_done !== 1'b0) idle_err++;
        step();
      end
      check_val("no_second_frame", 32'(idle_err), 32'd0);
    end
  endtask

  initial begin
    logic [19:0] p1;
    logic [19:0] p2;
    RST            = 1'b0;
    bus_if.tx_vld  = 1'b0;
    bus_if.tx_data = 20'h0;
    repeat (3) step();
    check_val("reset_tx", 32'(bus_if.tx), 32'd1);
    check_val("reset_rdy", 32'(bus_if.tx_rdy), 32'd0);
    check_val("reset_done", 32'(bus_if.tx_done), 32'd0);
    RST = 1'b1;
    step();
    check_val("rdy_after_reset", 32'(bus_if.tx_rdy), 32'd1);
    step();

    // Directed encoding frame: bytes A3, F1, C2.
    run_frame(20'h3F1C2, 0, 20'h0);
    // Busy request ignored.
    run_frame(20'h3F1C2, 1, 20'h0);
    // Held request: two frames separated by exactly the done cycle.
    p1 = 20'($urandom);
    p2 = 20'($urandom);
    run_frame(p1, 2, p2);
    run_frame(p2, 0, 20'h0);
    // Reset mid-frame.
    run_frame(20'($urandom), 3, 20'h0);
    // Random payloads.
    for (int i = 0; i < 100; i++) begin
      run_frame(20'($urandom), 0, 20'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_24bits.md
TX_24BITS -- requirements
Module: tx_24bits

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003 CLK  input  1  single clock; all logic on its rising edge.
REQ-004 RST  input  1  synchronous reset, active-low; sampled on rising edge of CLK.
REQ-005 tx_data  input  20  payload; [19:10] = control_x, [9:0] = control_y.
REQ-006 tx_vld  input  1  request to send tx_data as one frame.
REQ-007 tx_rdy  output  1  high when the block can accept a request.
REQ-008 tx  output  1  serial line, idle high.
REQ-009 tx_done  output  1  one-cycle pulse when a frame's final stop bit completes.

Function
REQ-010 CLKS_PER_BIT SHALL equal floor(CLK_FREQ/BAUD); each serial bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-011 A frame SHALL be 3 UART bytes, 8N1: start bit 0, 8 data bits LSB-first, 1 stop bit 1, no parity.
REQ-012 Byte order: byte0 = {4'hA, tx_data[19:16]}, byte1 = tx_data[15:8], byte2 = tx_data[7:0].
REQ-013 Bytes within a frame SHALL be back-to-back: the start bit of byte n+1 follows the stop bit of byte n with no idle cycles.
REQ-014 Frame length SHALL be 30*CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop-bit cycle.
REQ-015 A request SHALL be accepted on a rising edge where tx_vld=1 and tx_rdy=1; tx_data SHALL be captured in that same cycle.
REQ-016 tx_rdy SHALL fall in the cycle after acceptance and stay low until the frame ends.
REQ-017 tx_vld while tx_rdy=0 SHALL be ignored, not queued; tx_data changes during a frame SHALL NOT affect it.
REQ-018 The start bit of byte0 SHALL drive tx=0 starting in the cycle after acceptance (latency 1).
REQ-019 FSM states: IDLE, START, DATA, STOP.
REQ-020 FSM transitions: IDLE->START on accept; START->DATA after 1 bit time; DATA->STOP after 8 bits; STOP->START if byte index<2, else STOP->IDLE.
REQ-021 Counters: baud counter 0..CLKS_PER_BIT-1, bit index 0..7, byte index 0..2; each SHALL wrap to 0 at the end of its range.
REQ-022 On STOP->IDLE, tx_done SHALL pulse for 1 cycle and tx_rdy SHALL be high in that same cycle.
REQ-023 tx_vld held high SHALL be accepted at that IDLE cycle, so the gap between frames is 1 cycle of idle high.
REQ-024 In IDLE, tx SHALL be 1; tx SHALL be registered (glitch-free, no combinational path from inputs).

Reset
REQ-025 While RST=0: tx=1, tx_rdy=0, tx_done=0, FSM=IDLE, all counters 0, data register 0.
REQ-026 tx_rdy SHALL rise in the first cycle after RST returns high.
REQ-027 RST asserted mid-frame SHALL abort the frame at the next edge: tx=1, no tx_done, and no resumption after release.

Structure
REQ-028 Package car_uart_pkg SHALL hold the state enum, the sync nibble 4'hA, FRAME_BYTES=3, and the CLKS_PER_BIT derivation function.
REQ-029 One sub-module, uart_baud_gen, SHALL produce a one-cycle bit_tick every CLKS_PER_BIT cycles.
REQ-030 uart_baud_gen SHALL be cleared on frame start so the first bit is full length.

Verification (CLK_FREQ=160, BAUD=10 -> CLKS_PER_BIT=16)
REQ-031 Frame encoding: tx_data=20'h3F_1C2 (x=10'h0FC, y=10'h1C2) -> bytes 0xA3, 0xF1, 0xC2 on tx, each bit 16 cycles; tx_done 480 cycles after the first start-bit cycle.
REQ-032 Busy request ignored: second tx_vld with 20'h00001 at cycle 100 of the frame -> ignored; original bytes unchanged; no second frame.
REQ-033 Held tx_vld: tx_vld held high for two frames -> second start bit 1 idle cycle after tx_done; both frames decode correctly.
REQ-034 Reset mid-frame: RST=0 at cycle 200 of the frame -> tx=1 next edge; after release tx_rdy=1, no tx_done, line stays high.
REQ-035 Timing check: a scoreboard UART model samples mid-bit over 100 random payloads -> zero mismatches and every bit width exactly 16 cycles.
